// File: rtl/hub_poller_if.sv
// Request/response handshake bundle between the hub controller and hub_poller.
// The poller uses the slave modport; the controller side uses master.
interface hub_poller_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [1:0] req_data;
    logic       resp_valid;
    logic [1:0] resp_data;
    logic       resp_timeout;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, resp_valid, resp_data, resp_timeout
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, resp_valid, resp_data, resp_timeout
    );
endinterface

// File: rtl/hub_poller.sv
// Hub-side node bus initiator: sends a 4-bit {addr,data} frame on a tick grid and collects
// the node's reply or times out. Optional macro HUB_POLLER_RETRY_EN resends once on timeout.
module hub_poller #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic         clock50,
    input  logic         reset_n,
    hub_poller_if.slave  hub,
    output logic [3:0]   bus_out,
    input  logic [1:0]   bus_in,
    output logic         busy
);

    localparam int unsigned CntW    = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
    localparam logic [7:0]      WaitMax = 8'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StReject, StArm, StDrive, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]      wait_q, wait_d, wait_inc;
    logic [1:0]      addr_q, addr_d;
    logic [1:0]      data_q, data_d;
    logic [3:0]      bus_out_q, bus_out_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_timeout_q, resp_timeout_d;
    logic [1:0]      resp_data_q, resp_data_d;
    logic            tick;
`ifdef HUB_POLLER_RETRY_EN
    logic            retry_q, retry_d;
`endif

    always_ff @(posedge clock50) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            tick_cnt_q     <= '0;
            wait_q         <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            bus_out_q      <= '0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_data_q    <= '0;
`ifdef HUB_POLLER_RETRY_EN
            retry_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            wait_q         <= wait_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            bus_out_q      <= bus_out_d;
            resp_valid_q   <= resp_valid_d;
            resp_timeout_q <= resp_timeout_d;
            resp_data_q    <= resp_data_d;
`ifdef HUB_POLLER_RETRY_EN
            retry_q        <= retry_d;
`endif
        end
    end

    always_comb begin
        tick           = (tick_cnt_q == CntMax);
        tick_cnt_d     = tick ? '0 : tick_cnt_q + 1'b1;
        state_d        = state_q;
        wait_d         = wait_q;
        addr_d         = addr_q;
        data_d         = data_q;
        bus_out_d      = bus_out_q;
        resp_valid_d   = 1'b0;
        resp_timeout_d = 1'b0;
        resp_data_d    = resp_data_q;
        // Saturating increment; the counter must never wrap back under TIMEOUT.
        wait_inc       = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
`ifdef HUB_POLLER_RETRY_EN
        retry_d        = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (hub.req_valid) begin
                    addr_d  = hub.req_addr;
                    data_d  = hub.req_data;
                    state_d = (hub.req_addr != 2'd0) ? StArm : StReject;
`ifdef HUB_POLLER_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            StReject: begin
                resp_timeout_d = 1'b1;
                state_d        = StIdle;
            end
            StArm: begin
                if (tick) begin
                    bus_out_d = {addr_q, data_q};
                    wait_d    = '0;
                    state_d   = StDrive;
                end
            end
            StDrive: begin
                if (tick) begin
                    bus_out_d = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (tick) begin
                    if (bus_in != 2'd0) begin
                        // A reply on the final tick beats the timeout.
                        resp_data_d  = bus_in;
                        resp_valid_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        wait_d = wait_inc;
                        if (wait_inc >= WaitMax) begin
`ifdef HUB_POLLER_RETRY_EN
                            if (!retry_q) begin
                                retry_d = 1'b1;
                                wait_d  = '0;
                                state_d = StArm;
                            end else begin
                                resp_timeout_d = 1'b1;
                                state_d        = StIdle;
                            end
`else
                            resp_timeout_d = 1'b1;
                            state_d        = StIdle;
`endif
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign hub.req_ready    = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign hub.resp_valid   = resp_valid_q;
    assign hub.resp_timeout = resp_timeout_q;
    assign hub.resp_data    = resp_data_q;
    assign bus_out          = bus_out_q;

endmodule

// File: tb/tb_hub_poller.sv
// Randomized scoreboard bench for hub_poller with a behavioural node model.
module tb_hub_poller;

    localparam int TICK_DIV = 4;
    localparam int TIMEOUT  = 3;
    localparam int NEVER    = TIMEOUT + 1;
`ifdef HUB_POLLER_RETRY_EN
    localparam int TMO_FRAMES = 2;
`else
    localparam int TMO_FRAMES = 1;
`endif

    typedef struct {
        bit         tmo;
        logic [1:0] data;
        int         frames;
    } exp_t;

    logic       clock50;
    logic       reset_n;
    logic [3:0] bus_out;
    logic [1:0] bus_in;
    logic       busy;

    hub_poller_if hif ();

    hub_poller #(
        .TICK_DIV (TICK_DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock50 (clock50),
        .reset_n (reset_n),
        .hub     (hif),
        .bus_out (bus_out),
        .bus_in  (bus_in),
        .busy    (busy)
    );

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cur_k   = NEVER;
    logic [1:0] cur_r   = 2'd0;
    logic [3:0] cur_frame = 4'd0;
    logic [1:0] last_data = 2'd0;
    int         frames_seen = 0;
    int         flen = 0;
    bit         in_rst_test = 0;

    initial begin
        clock50 = 1'b0;
        forever #5 clock50 = ~clock50;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Node model: replies with cur_r at the cur_k-th WAIT tick after each frame.
    initial begin
        bus_in = 2'd0;
        forever begin
            @(negedge clock50);
            if (bus_out != 4'd0 && reset_n) begin
                if (cur_k <= TIMEOUT) begin
                    repeat (TICK_DIV * cur_k) @(posedge clock50);
                    #1 bus_in = cur_r;
                    repeat (TICK_DIV) @(posedge clock50);
                    #1 bus_in = 2'd0;
                end else begin
                    while (bus_out != 4'd0) @(negedge clock50);
                end
            end
        end
    end

    // Monitor: frame shape tracking and scoreboard pops on every response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock50);
            if (bus_out != 4'd0) begin
                if (flen == 0) begin
                    frames_seen++;
                    chk("frame_value", 32'(bus_out), 32'(cur_frame));
                end
                flen++;
            end else if (flen != 0) begin
                if (!in_rst_test) chk("frame_len", flen, TICK_DIV);
                flen = 0;
            end
            if (hif.resp_valid || hif.resp_timeout) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: valid=%0b timeout=%0b expected none",
                             hif.resp_valid, hif.resp_timeout);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {30'd0, hif.resp_valid, hif.resp_timeout},
                        e.tmo ? 32'd1 : 32'd2);
                    if (!e.tmo) last_data = e.data;
                    chk("resp_data", 32'(hif.resp_data), 32'(last_data));
                    chk("frame_count", frames_seen, e.frames);
                    chk("ready_at_pulse", 32'(hif.req_ready), 32'd1);
                    chk("busy_at_pulse", 32'(busy), 32'd0);
                end
                frames_seen = 0;
            end
        end
    end

    task automatic send(input logic [1:0] addr, input logic [1:0] data);
        int n;
        n = 0;
        @(negedge clock50);
        while (!hif.req_ready && n < 100) begin
            @(negedge clock50);
            n++;
        end
        hif.req_valid = 1'b1;
        hif.req_addr  = addr;
        hif.req_data  = data;
        @(posedge clock50);
        #1 hif.req_valid = 1'b0;
    endtask

    // Reference: reject -> timeout, no frame; reply within TIMEOUT ticks wins; else timeout.
    task automatic transact(input logic [1:0] addr, input logic [1:0] data,
                            input int k, input logic [1:0] r);
        exp_t e;
        int   n;
        cur_k     = k;
        cur_r     = r;
        cur_frame = {addr, data};
        if (addr == 2'd0) begin
            e.tmo = 1; e.data = 2'd0; e.frames = 0;
        end else if (k <= TIMEOUT) begin
            e.tmo = 0; e.data = r; e.frames = 1;
        end else begin
            e.tmo = 1; e.data = 2'd0; e.frames = TMO_FRAMES;
        end
        sb.push_back(e);
        send(addr, data);
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clock50);
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL response_wait: got no pulse expected one within 300 cycles");
            sb.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n       = 1'b0;
        hif.req_valid = 1'b1;
        hif.req_addr  = 2'd2;
        hif.req_data  = 2'd1;
        repeat (2) @(negedge clock50);
        for (int i = 0; i < 3; i++) begin
            chk("rst_bus_out", 32'(bus_out), 32'd0);
            chk("rst_resp", {29'd0, hif.resp_valid, hif.resp_timeout, busy}, 32'd0);
            chk("rst_resp_data", 32'(hif.resp_data), 32'd0);
            chk("rst_ready", 32'(hif.req_ready), 32'd1);
            @(negedge clock50);
        end
        hif.req_valid = 1'b0;
        reset_n       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock50);
            chk("idle_bus_out", 32'(bus_out), 32'd0);
            chk("idle_ready", 32'(hif.req_ready), 32'd1);
        end

        transact(2'd2, 2'd1, 1, 2'd2);
        transact(2'd3, 2'd3, NEVER, 2'd0);
        transact(2'd0, 2'd2, 1, 2'd1);
        transact(2'd1, 2'd0, TIMEOUT, 2'd1);
        transact(2'd0, 2'd0, 1, 2'd3);

        // Reset in the middle of DRIVE drops the transaction silently.
        in_rst_test = 1;
        cur_k       = NEVER;
        cur_frame   = {2'd1, 2'd2};
        send(2'd1, 2'd2);
        n = 0;
        while (bus_out == 4'd0 && n < 50) begin
            @(negedge clock50);
            n++;
        end
        chk("drive_reached", 32'(bus_out), 32'(cur_frame));
        @(negedge clock50);
        reset_n = 1'b0;
        @(negedge clock50);
        chk("mid_rst_bus_out", 32'(bus_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_resp_data", 32'(hif.resp_data), 32'd0);
        repeat (2) @(negedge clock50);
        reset_n     = 1'b1;
        last_data   = 2'd0;
        frames_seen = 0;
        in_rst_test = 0;
        transact(2'd1, 2'd2, 1, 2'd3);

        for (int i = 0; i < 30; i++) begin
            transact(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(1, NEVER)), 2'($urandom_range(1, 3)));
        end

        repeat (5) @(negedge clock50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
